// File: rtl/retire_trace_unit.sv
// Shadow pipeline that follows each instruction to write-back and emits one commit record per retire.
// Records appear on trace_* 5 cycles after fetch through a DEPTH-entry FIFO; a full FIFO drops and counts, never stalls the core.
`timescale 1ns/1ps
module retire_trace_unit #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [31:0]      pc_fetch,
  input  logic [31:0]      instr_fetch,
  input  logic             is_r_type_iss,
  input  logic             is_i_type_iss,
  input  logic             is_j_type_iss,
  input  logic [4:0]       rs_iss,
  input  logic [4:0]       rt_iss,
  input  logic [4:0]       rd_iss,
  input  logic             stall,
  input  logic             flush,
  input  logic             reg_wr_wb,
  input  logic [4:0]       wr_addr_wb,
  input  logic [31:0]      wr_data_wb,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_pc,
  output logic [31:0]      trace_instr,
  output logic [1:0]       trace_type,
  output logic             trace_wen,
  output logic [4:0]       trace_dest,
  output logic [31:0]      trace_wdata,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  typ;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } stage_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  typ;
    logic        wen;
    logic [4:0]  dest;
    logic [31:0] wdata;
  } rec_t;

  logic             iss_v_q, iss_v_d;
  logic [31:0]      iss_pc_q, iss_pc_d, iss_instr_q, iss_instr_d;
  stage_t           ex_q, ex_d, mem_q, mem_d, wb_q, wb_d;
  rec_t             wb_rec, out_q, out_d;
  rec_t             buf_q [DEPTH];
  rec_t             buf_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop, drop, push_acc;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d, drop_cnt_q, drop_cnt_d;
  logic             overflow_q, overflow_d;

  // Flush kills both the instruction leaving ISS and the one arriving from fetch, even under stall.
  always_comb begin
    iss_v_d     = iss_v_q;
    iss_pc_d    = iss_pc_q;
    iss_instr_d = iss_instr_q;
    if (!stall) begin
      iss_v_d     = fetch_valid;
      iss_pc_d    = pc_fetch;
      iss_instr_d = instr_fetch;
    end
    if (flush) iss_v_d = 1'b0;

    ex_d.v     = iss_v_q & ~stall & ~flush;
    ex_d.pc    = iss_pc_q;
    ex_d.instr = iss_instr_q;
    ex_d.rs    = rs_iss;
    ex_d.rt    = rt_iss;
    ex_d.rd    = rd_iss;
    if (is_r_type_iss)      ex_d.typ = 2'b00;
    else if (is_i_type_iss) ex_d.typ = 2'b01;
    else if (is_j_type_iss) ex_d.typ = 2'b10;
    else                    ex_d.typ = 2'b11;

    mem_d = ex_q;
    wb_d  = mem_q;
  end

  always_comb begin
    wb_rec.pc    = wb_q.pc;
    wb_rec.instr = wb_q.instr;
    wb_rec.typ   = wb_q.typ;
    wb_rec.wen   = reg_wr_wb && (wr_addr_wb != 5'd0);
    wb_rec.dest  = wb_rec.wen ? wr_addr_wb : 5'd0;
    wb_rec.wdata = wb_rec.wen ? wr_data_wb : 32'd0;
  end

  // out_q mirrors the head entry of the next cycle, bypassing the record being written when it becomes head.
  always_comb begin
    pop      = (count_q != '0) && trace_ready;
    push     = wb_q.v;
    drop     = push && (count_q == FULL_CNT) && !pop;
    push_acc = push && !drop;

    buf_d = buf_q;
    if (push_acc) buf_d[wr_ptr_q] = wb_rec;
    wr_ptr_d = push_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (push_acc && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push_acc && pop) count_d = count_q - (AW+1)'(1);

    out_d = out_q;
    if (count_d != '0)
      out_d = (push_acc && (rd_ptr_d == wr_ptr_q)) ? wb_rec : buf_q[rd_ptr_d];

    retire_cnt_d = wb_q.v ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
    drop_cnt_d   = (drop && (drop_cnt_q != '1)) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
    overflow_d   = overflow_q | drop;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      iss_v_q      <= 1'b0;
      iss_pc_q     <= '0;
      iss_instr_q  <= '0;
      ex_q         <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      out_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      retire_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      iss_v_q      <= iss_v_d;
      iss_pc_q     <= iss_pc_d;
      iss_instr_q  <= iss_instr_d;
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      out_q        <= out_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      retire_cnt_q <= retire_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever read.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  logic unused_idx;
  assign unused_idx = ^{wb_q.rs, wb_q.rt, wb_q.rd};

  assign trace_valid = (count_q != '0);
  assign trace_pc    = out_q.pc;
  assign trace_instr = out_q.instr;
  assign trace_type  = out_q.typ;
  assign trace_wen   = out_q.wen;
  assign trace_dest  = out_q.dest;
  assign trace_wdata = out_q.wdata;
  assign retire_cnt  = retire_cnt_q;
  assign drop_cnt    = drop_cnt_q;
  assign overflow    = overflow_q;
endmodule

// File: tb/tb_retire_trace_unit.sv
// Directed bench for retire_trace_unit: straight-line, stall, flush, $zero writes, overflow and mid-run reset.
`timescale 1ns/1ps
module tb_retire_trace_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] pc_fetch, instr_fetch;
  logic        is_r_type_iss, is_i_type_iss, is_j_type_iss;
  logic [4:0]  rs_iss, rt_iss, rd_iss;
  logic        stall, flush;
  logic        reg_wr_wb;
  logic [4:0]  wr_addr_wb;
  logic [31:0] wr_data_wb;
  logic        trace_valid, trace_ready;
  logic [31:0] trace_pc, trace_instr;
  logic [1:0]  trace_type;
  logic        trace_wen;
  logic [4:0]  trace_dest;
  logic [31:0] trace_wdata;
  logic [31:0] retire_cnt, drop_cnt;
  logic        overflow;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  retire_trace_unit #(.DEPTH(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .fetch_valid(fetch_valid), .pc_fetch(pc_fetch), .instr_fetch(instr_fetch),
    .is_r_type_iss(is_r_type_iss), .is_i_type_iss(is_i_type_iss), .is_j_type_iss(is_j_type_iss),
    .rs_iss(rs_iss), .rt_iss(rt_iss), .rd_iss(rd_iss),
    .stall(stall), .flush(flush),
    .reg_wr_wb(reg_wr_wb), .wr_addr_wb(wr_addr_wb), .wr_data_wb(wr_data_wb),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_instr(trace_instr), .trace_type(trace_type),
    .trace_wen(trace_wen), .trace_dest(trace_dest), .trace_wdata(trace_wdata),
    .retire_cnt(retire_cnt), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  // Drive one cycle of inputs, then sample 1ns after the edge that consumes them.
  task automatic tick(input logic fv, input logic [31:0] pc, input logic [2:0] flg,
                      input logic st, input logic fl);
    fetch_valid = fv;
    pc_fetch    = pc;
    instr_fetch = 32'h2400_0000 | pc;
    {is_r_type_iss, is_i_type_iss, is_j_type_iss} = flg;
    stall = st;
    flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; trace_ready = 1'b1;
    reg_wr_wb = 1'b1; wr_addr_wb = 5'd9; wr_data_wb = 32'hDEAD;
    rs_iss = 5'd1; rt_iss = 5'd2; rd_iss = 5'd3;
    tick(1'b1, 32'h40, 3'b100, 1'b0, 1'b0);
    tick(1'b1, 32'h44, 3'b100, 1'b0, 1'b0);
    checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", trace_valid); end
    checks++; if (trace_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", trace_pc); end
    checks++; if (trace_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", trace_instr); end
    checks++; if ({trace_type, trace_wen, trace_dest} !== 8'h0) begin errors++; $display("FAIL reset_type_wen_dest got %h exp 0", {trace_type, trace_wen, trace_dest}); end
    checks++; if (trace_wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", trace_wdata); end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL reset_retire_cnt got %0d exp 0", retire_cnt); end
    checks++; if (drop_cnt !== 32'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d exp 0", drop_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b exp 0", overflow); end
    reset = 1'b1;
  endtask

  task automatic test_straight();
    logic [2:0] flg [4];
    logic [1:0] ty [4];
    flg[0] = 3'b110; flg[1] = 3'b011; flg[2] = 3'b001; flg[3] = 3'b000;
    ty[0]  = 2'b00;  ty[1]  = 2'b01;  ty[2]  = 2'b10;  ty[3]  = 2'b11;
    do_reset();
    trace_ready = 1'b1; reg_wr_wb = 1'b1; wr_addr_wb = 5'd3; wr_data_wb = 32'hA5;
    for (int i = 0; i < 9; i++) begin
      tick(i < 4, 32'(4*i), (i >= 1 && i <= 4) ? flg[i-1] : 3'b000, 1'b0, 1'b0);
      if (i == 3) begin
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL straight_early_valid got %0b exp 0", trace_valid); end
      end
      if (i >= 4 && i <= 7) begin
        checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL straight_valid i=%0d got %0b exp 1", i, trace_valid); end
        checks++; if (trace_pc !== 32'(4*(i-4))) begin errors++; $display("FAIL straight_pc i=%0d got %h exp %h", i, trace_pc, 32'(4*(i-4))); end
        checks++; if (trace_instr !== (32'h2400_0000 | 32'(4*(i-4)))) begin errors++; $display("FAIL straight_instr i=%0d got %h", i, trace_instr); end
        checks++; if (trace_type !== ty[i-4]) begin errors++; $display("FAIL straight_type i=%0d got %b exp %b", i, trace_type, ty[i-4]); end
      end
      if (i == 4) begin
        checks++; if ({trace_wen, trace_dest, trace_wdata} !== {1'b1, 5'd3, 32'hA5}) begin errors++; $display("FAIL straight_wb got wen=%0b dest=%0d data=%h exp 1/3/a5", trace_wen, trace_dest, trace_wdata); end
      end
      if (i == 8) begin
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL straight_drained got %0b exp 0", trace_valid); end
        checks++; if (retire_cnt !== 32'd4) begin errors++; $display("FAIL straight_retire_cnt got %0d exp 4", retire_cnt); end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(i <= 4, (i <= 2) ? 32'(4*i) : 32'hC, 3'b000, i == 3, 1'b0);
      if (i == 4 || i == 5 || i == 7 || i == 8) begin
        logic [31:0] exp_pc;
        exp_pc = (i == 4) ? 32'h0 : (i == 5) ? 32'h4 : (i == 7) ? 32'h8 : 32'hC;
        checks++; if (trace_valid !== 1'b1 || trace_pc !== exp_pc) begin errors++; $display("FAIL stall_rec i=%0d got v=%0b pc=%h exp 1/%h", i, trace_valid, trace_pc, exp_pc); end
      end
      if (i == 6) begin
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL stall_bubble got %0b exp 0", trace_valid); end
        checks++; if (retire_cnt !== 32'd2) begin errors++; $display("FAIL stall_bubble_cnt got %0d exp 2", retire_cnt); end
      end
      if (i == 9) begin
        checks++; if (trace_valid !== 1'b0 || retire_cnt !== 32'd4) begin errors++; $display("FAIL stall_end got v=%0b cnt=%0d exp 0/4", trace_valid, retire_cnt); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      tick(i <= 5, (i <= 4) ? 32'(4*i) : 32'h40, 3'b000, 1'b0, i == 4);
      if (i == 4 || i == 5 || i == 6 || i == 9) begin
        logic [31:0] exp_pc;
        exp_pc = (i == 9) ? 32'h40 : 32'(4*(i-4));
        checks++; if (trace_valid !== 1'b1 || trace_pc !== exp_pc) begin errors++; $display("FAIL flush_rec i=%0d got v=%0b pc=%h exp 1/%h", i, trace_valid, trace_pc, exp_pc); end
      end
      if (i == 7 || i == 8) begin
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL flush_killed i=%0d got v=%0b pc=%h exp 0", i, trace_valid, trace_pc); end
      end
      if (i == 10) begin
        checks++; if (trace_valid !== 1'b0 || retire_cnt !== 32'd4) begin errors++; $display("FAIL flush_end got v=%0b cnt=%0d exp 0/4", trace_valid, retire_cnt); end
      end
    end
  endtask

  task automatic test_stall_flush();
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(i <= 2, 32'(4*i), 3'b000, i == 1, i == 1);
      if (i == 4 || i == 5) begin
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL stall_flush_killed i=%0d got v=%0b pc=%h exp 0", i, trace_valid, trace_pc); end
      end
      if (i == 6) begin
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h8) begin errors++; $display("FAIL stall_flush_next got v=%0b pc=%h exp 1/8", trace_valid, trace_pc); end
      end
      if (i == 7) begin
        checks++; if (retire_cnt !== 32'd1) begin errors++; $display("FAIL stall_flush_cnt got %0d exp 1", retire_cnt); end
      end
    end
  endtask

  task automatic test_zero_write();
    do_reset();
    trace_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      reg_wr_wb  = (i == 4 || i == 6);
      wr_addr_wb = (i == 4) ? 5'd0 : 5'd7;
      wr_data_wb = (i == 4) ? 32'd5 : 32'd9;
      tick(i <= 2, 32'(4*i), 3'b010, 1'b0, 1'b0);
      if (i == 4 || i == 5) begin
        checks++; if ({trace_valid, trace_wen, trace_dest, trace_wdata} !== {1'b1, 1'b0, 5'd0, 32'd0}) begin errors++; $display("FAIL zero_write i=%0d got v=%0b wen=%0b dest=%0d data=%h exp 1/0/0/0", i, trace_valid, trace_wen, trace_dest, trace_wdata); end
      end
      if (i == 6) begin
        checks++; if ({trace_wen, trace_dest, trace_wdata} !== {1'b1, 5'd7, 32'd9}) begin errors++; $display("FAIL zero_write_real got wen=%0b dest=%0d data=%h exp 1/7/9", trace_wen, trace_dest, trace_wdata); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    trace_ready = 1'b0; reg_wr_wb = 1'b1; wr_addr_wb = 5'd3; wr_data_wb = 32'h77;
    for (int i = 0; i < 17; i++) begin
      tick(i < 11, 32'(4*i), 3'b000, 1'b0, 1'b0);
      if (i == 11) begin
        checks++; if (overflow !== 1'b0 || drop_cnt !== 32'd0) begin errors++; $display("FAIL ovf_at_full got ovf=%0b drop=%0d exp 0/0", overflow, drop_cnt); end
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h0) begin errors++; $display("FAIL ovf_head_full got v=%0b pc=%h exp 1/0", trace_valid, trace_pc); end
      end
      if (i == 12) begin
        checks++; if (overflow !== 1'b1 || drop_cnt !== 32'd1) begin errors++; $display("FAIL ovf_first_drop got ovf=%0b drop=%0d exp 1/1", overflow, drop_cnt); end
      end
      if (i == 16) begin
        checks++; if (drop_cnt !== 32'd3 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop_cnt got drop=%0d ovf=%0b exp 3/1", drop_cnt, overflow); end
        checks++; if (retire_cnt !== 32'd11) begin errors++; $display("FAIL ovf_retire_cnt got %0d exp 11", retire_cnt); end
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h0) begin errors++; $display("FAIL ovf_head_stable got v=%0b pc=%h exp 1/0", trace_valid, trace_pc); end
      end
    end
    trace_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
      if (k < 8) begin
        checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'(4*k)) begin errors++; $display("FAIL ovf_drain k=%0d got v=%0b pc=%h exp 1/%h", k, trace_valid, trace_pc, 32'(4*k)); end
      end else begin
        checks++; if (trace_valid !== 1'b0 || trace_pc !== 32'h1C) begin errors++; $display("FAIL ovf_empty_hold got v=%0b pc=%h exp 0/1c", trace_valid, trace_pc); end
      end
    end
  endtask

  task automatic test_reset_mid();
    trace_ready = 1'b0;
    for (int i = 0; i < 7; i++) tick(i < 5, 32'h100 + 32'(4*i), 3'b000, 1'b0, 1'b0);
    checks++; if (trace_valid !== 1'b1 || trace_pc !== 32'h100) begin errors++; $display("FAIL midrst_pre got v=%0b pc=%h exp 1/100", trace_valid, trace_pc); end
    reset = 1'b0;
    tick(1'b1, 32'h200, 3'b000, 1'b0, 1'b0);
    reset = 1'b1;
    checks++; if (trace_valid !== 1'b0 || trace_pc !== 32'h0 || trace_wdata !== 32'h0) begin errors++; $display("FAIL midrst_trace got v=%0b pc=%h data=%h exp 0/0/0", trace_valid, trace_pc, trace_wdata); end
    checks++; if (retire_cnt !== 32'd0 || drop_cnt !== 32'd0 || overflow !== 1'b0) begin errors++; $display("FAIL midrst_cnt got ret=%0d drop=%0d ovf=%0b exp 0/0/0", retire_cnt, drop_cnt, overflow); end
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 32'h0, 3'b000, 1'b0, 1'b0);
      checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL midrst_stale i=%0d got v=%0b pc=%h exp 0", i, trace_valid, trace_pc); end
    end
    checks++; if (retire_cnt !== 32'd0) begin errors++; $display("FAIL midrst_retire got %0d exp 0", retire_cnt); end
  endtask

  initial begin
    reset = 1'b0; trace_ready = 1'b0;
    fetch_valid = 1'b0; pc_fetch = '0; instr_fetch = '0;
    is_r_type_iss = 1'b0; is_i_type_iss = 1'b0; is_j_type_iss = 1'b0;
    rs_iss = '0; rt_iss = '0; rd_iss = '0; stall = 1'b0; flush = 1'b0;
    reg_wr_wb = 1'b0; wr_addr_wb = '0; wr_data_wb = '0;
    test_reset();
    test_straight();
    test_stall();
    test_flush();
    test_stall_flush();
    test_zero_write();
    test_overflow();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/retire_trace_unit.md
Name: retire_trace_unit

Overview:
- Sits beside the 5-stage MIPS pipeline (fetch, issue, execute, memory, write-back).
- Carries a shadow copy of each instruction's pc, instr, type and register indices down the pipeline, honouring stall and flush.
- At write-back, packs the retired instruction and its architectural register update into a commit record. Records go through a small FIFO and out on a valid/ready trace port.
- The trace port feeds the reference-model comparator, or a future on-chip trace sink, so the checker no longer rebuilds stage timing itself.

Parameters:
- DEPTH, 8, trace FIFO entries; power of two, at least 2.
- CNT_W, 32, width of the retire and drop counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous reset, active-low (0 = reset).
- fetch_valid  in  1  fetch stage holds a real instruction.
- pc_fetch  in  32  fetch pc.
- instr_fetch  in  32  fetch instruction word.
- is_r_type_iss  in  1  decode result for the issue-stage instruction.
- is_i_type_iss  in  1  decode result for the issue-stage instruction.
- is_j_type_iss  in  1  decode result for the issue-stage instruction.
- rs_iss, rt_iss, rd_iss  in  5 each  register indices of the issue-stage instruction.
- stall  in  1  hold fetch/issue; insert a bubble into execute.
- flush  in  1  kill the issue-stage and execute-stage instructions (taken branch or jump).
- reg_wr_wb  in  1  write-back register write enable.
- wr_addr_wb  in  5  write-back destination register.
- wr_data_wb  in  32  write-back data.
- trace_valid  out  1  head record available.
- trace_ready  in  1  consumer accepts the head record.
- trace_pc  out  32  head record pc.
- trace_instr  out  32  head record instruction word.
- trace_type  out  2  head record type: 00 R, 01 I, 10 J, 11 other.
- trace_wen  out  1  head record register-write flag.
- trace_dest  out  5  head record destination register.
- trace_wdata  out  32  head record write data.
- retire_cnt  out  CNT_W  instructions retired.
- drop_cnt  out  CNT_W  records lost to a full FIFO.
- overflow  out  1  sticky; set by the first drop.

Behaviour:
- Reset (reset == 0 at clk edge):
  - All shadow valid bits 0; FIFO empty.
  - trace_valid = 0; all trace_* data outputs = 0.
  - retire_cnt = 0, drop_cnt = 0, overflow = 0.
  - Applies mid-operation: any in-flight or buffered records are discarded.
- Shadow pipeline: four registered stages ISS, EX, MEM, WB, each holding {v, pc, instr, type, rs, rt, rd}.
  - ISS <= {fetch_valid, pc_fetch, instr_fetch} when stall = 0; held when stall = 1.
  - Type and indices are captured from the *_iss inputs on the ISS->EX transfer.
  - EX <= ISS, with v cleared when stall = 1 (bubble).
  - MEM <= EX; WB <= MEM; these two never stall.
- Flush: clears ISS.v and the v of the value entering EX on that edge. It also clears the ISS.v written from fetch on that edge.
- Stall and flush together: flush wins; ISS.v = 0 and the EX bubble is inserted.
- Type encoding: R if is_r_type, else I if is_i_type, else J if is_j_type, else 11. If more than one flag is set, R has priority over I, and I over J.
- Retire: every cycle with WB.v = 1 produces one record:
  - {WB.pc, WB.instr, WB.type, reg_wr_wb, wr_addr_wb, wr_data_wb}.
  - If reg_wr_wb = 0 or wr_addr_wb = 0, then trace_wen = 0 and trace_dest/trace_wdata are forced to 0. Writes to $zero are not architectural.
  - retire_cnt increments per retired record, wrapping at 2^CNT_W.
  - Latency: an instruction in fetch at cycle t with no stall/flush retires in the WB register at t+4. Its record is visible on trace_* at t+5 when the FIFO was empty.
- FIFO: DEPTH entries, registered read port. trace_* show the head entry.
  - Pop when trace_valid && trace_ready.
  - Push and pop in the same cycle are allowed at any occupancy, including full; count is unchanged.
  - Push when full with no pop: record dropped, drop_cnt += 1 (saturating at all ones), overflow <= 1. The pipeline is never back-pressured.
  - Empty: trace_valid = 0; data outputs hold the last popped values.
  - Pointers wrap modulo DEPTH.
  - trace_* stay stable while trace_valid = 1 and trace_ready = 0.

Test Plan:
- Straight-line retire: 4 instrs at pc 0x0, 0x4, 0x8, 0xC, no stall, trace_ready = 1 -> four records in order; the first has trace_valid = 1 exactly 5 cycles after its fetch. retire_cnt = 4.
- Stall: one-cycle stall while instr pc = 0x8 is in ISS -> pc 0x8 retires once, one cycle later than unstalled; no duplicate and no gap record; retire_cnt unchanged by the bubble.
- Flush: flush asserted with pc 0x10 in ISS and pc 0x0C entering EX -> neither 0x10 nor 0x0C appears on the trace; the next record is the branch target.
- $zero write: addiu $0,$0,5 with reg_wr_wb = 1, wr_addr_wb = 0 -> record with trace_wen = 0, trace_dest = 0, trace_wdata = 0.
- Overflow: trace_ready = 0 for DEPTH+3 retires -> DEPTH records held, drop_cnt = 3, overflow = 1. After releasing ready, the first DEPTH records drain in order.
- Reset mid-run: reset = 0 for one edge while the FIFO holds 3 records -> trace_valid = 0, all counters 0, overflow = 0 on the next cycle. No stale records after release.
